// File: rtl/frame_pkg.sv
// Shared constants and FSM state encoding for the frame header inserter.
package frame_pkg;

    localparam logic [31:0] SYNC_WORD = 32'hA5A5_5A5A;
    localparam int          HDR_LEN   = 3;

    // The last header state's code equals the header length, so HDR2 closes the header.
    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_HDR0   = 2'd1,
        ST_HDR1   = 2'd2,
        ST_HDR2   = 2'(HDR_LEN)
    } hdr_state_e;

    function automatic logic [31:0] count_step(input logic [31:0] cnt, input logic inc);
        return cnt + {31'd0, inc};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock FIFO with registered read data (one-cycle read latency).
module sample_fifo #(
    parameter int DW = 32,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty
);

    logic [DW-1:0] mem_r [0:(1<<AW)-1];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [DW-1:0] rd_data_r;

    // Pointers carry one extra wrap bit to tell full from empty.
    always_comb begin
        empty = (wr_ptr_r == rd_ptr_r);
        full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

    // Pointer and read-data registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            rd_data_r <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr_r  <= rd_ptr_r + (AW+1)'(1);
                rd_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            end
        end
    end

    assign rd_data = rd_data_r;

endmodule

// File: rtl/frame_hdr_insert.sv
// Splits the sample stream into frames, inserting a 3-word header on each
// frame-marker rising edge while incoming samples wait in a small FIFO.
module frame_hdr_insert
    import frame_pkg::*;
#(
    parameter int DW      = 32,
    parameter int FIFO_AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ms_in,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic [DW-1:0] dout,
    output logic          dout_valid,
    output logic          dout_sof,
    output logic [31:0]   frame_num,
    output logic          overflow
);

    hdr_state_e    state_r, state_nxt_s;
    logic          ms_q_r;
    logic          edge_s;
    logic [31:0]   cnt_r, snap_r, pend_snap_r, frame_num_r;
    logic          pend_r, overflow_r;
    logic          rd_en_s, wr_en_s, take_pend_s, snap_start_s;
    logic          fifo_full_s, fifo_empty_s;
    logic [DW-1:0] fifo_q_s;
    logic [DW-1:0] hdr_word_s, hdr_word_r;
    logic          hdr_sel_r, dout_valid_r, dout_sof_r;

    assign edge_s = ms_in & ~ms_q_r;

    // A full FIFO still accepts a write when a read frees a slot in the same cycle.
    assign wr_en_s = din_valid & (~fifo_full_s | rd_en_s);

    sample_fifo #(.DW(DW), .AW(FIFO_AW)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .wr_data (din),
        .rd_en   (rd_en_s),
        .rd_data (fifo_q_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Next-state, FIFO pop and header word selection.
    always_comb begin
        state_nxt_s  = state_r;
        rd_en_s      = 1'b0;
        take_pend_s  = 1'b0;
        snap_start_s = 1'b0;
        hdr_word_s   = '0;
        case (state_r)
            ST_STREAM: begin
                if (pend_r) begin
                    state_nxt_s = ST_HDR0;
                    take_pend_s = 1'b1;
                end else begin
                    rd_en_s = ~fifo_empty_s;
                    if (edge_s) begin
                        state_nxt_s  = ST_HDR0;
                        snap_start_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_STREAM;
                    end
                end
            end
            ST_HDR0: begin
                state_nxt_s = ST_HDR1;
                hdr_word_s  = DW'(SYNC_WORD);
            end
            ST_HDR1: begin
                state_nxt_s = ST_HDR2;
                hdr_word_s  = DW'(frame_num_r);
            end
            ST_HDR2: begin
                state_nxt_s = ST_STREAM;
                hdr_word_s  = DW'(snap_r);
            end
            default: begin
                state_nxt_s = ST_STREAM;
            end
        endcase
    end

    // State register and marker delay.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_STREAM;
            ms_q_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            ms_q_r  <= ms_in;
        end
    end

    // Sample counter, frame snapshots and the single pending-marker slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r       <= 32'd0;
            snap_r      <= 32'd0;
            pend_snap_r <= 32'd0;
            pend_r      <= 1'b0;
        end else begin
            if (edge_s) begin
                cnt_r <= 32'd0;
            end else begin
                cnt_r <= count_step(cnt_r, din_valid);
            end
            if (snap_start_s) begin
                snap_r <= count_step(cnt_r, din_valid);
            end else if (take_pend_s) begin
                snap_r <= pend_snap_r;
            end
            // A sample on the edge cycle still belongs to the closing frame.
            if (take_pend_s) begin
                pend_r <= 1'b0;
            end else if (edge_s && (state_r != ST_STREAM) && !pend_r) begin
                pend_r      <= 1'b1;
                pend_snap_r <= count_step(cnt_r, din_valid);
            end
        end
    end

    // Frame number advances once the HDR2 word has been issued; overflow is sticky.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_num_r <= 32'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (state_r == ST_HDR2) begin
                frame_num_r <= frame_num_r + 32'd1;
            end
            if (din_valid && fifo_full_s && !rd_en_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Output qualifiers and header word, aligned with the FIFO read-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_sel_r    <= 1'b0;
            hdr_word_r   <= '0;
            dout_valid_r <= 1'b0;
            dout_sof_r   <= 1'b0;
        end else begin
            hdr_sel_r    <= (state_r != ST_STREAM);
            hdr_word_r   <= hdr_word_s;
            dout_valid_r <= (state_r != ST_STREAM) | rd_en_s;
            dout_sof_r   <= (state_r == ST_HDR0);
        end
    end

    // Output mux between registered header word and registered FIFO data.
    always_comb begin
        dout = fifo_q_s;
        if (hdr_sel_r) begin
            dout = hdr_word_r;
        end else begin
            dout = fifo_q_s;
        end
    end

    assign dout_valid = dout_valid_r;
    assign dout_sof   = dout_sof_r;
    assign frame_num  = frame_num_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_frame_hdr_insert.sv
// Scoreboard bench for frame_hdr_insert: directed stimulus pushes expected
// words, a negedge monitor pops and compares every valid output word.
module tb_frame_hdr_insert;

    localparam logic [31:0] EXP_SYNC = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ms_in = 1'b0;
    logic [31:0] din = 32'd0;
    logic        din_valid = 1'b0;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_sof;
    logic [31:0] frame_num;
    logic        overflow;

    typedef struct packed {
        logic [31:0] d;
        logic        sof;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   chk_en = 1'b1;

    frame_hdr_insert #(.DW(32), .FIFO_AW(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .ms_in      (ms_in),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .frame_num  (frame_num),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic sof);
        exp_t e;
        e.d   = d;
        e.sof = sof;
        exp_q.push_back(e);
    endtask

    task automatic push_hdr(input logic [31:0] fn, input logic [31:0] snap);
        push(EXP_SYNC, 1'b1);
        push(fn, 1'b0);
        push(snap, 1'b0);
    endtask

    // One clock of stimulus; returns 1 time unit after the next rising edge.
    task automatic drive(input logic ms, input logic dv, input logic [31:0] d);
        ms_in     = ms;
        din_valid = dv;
        din       = d;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            drive(1'b0, 1'b0, 32'd0);
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) drive(1'b0, 1'b0, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        repeat (2) drive(1'b0, 1'b0, 32'd0);
        rst = 1'b0;
    endtask

    // Monitor: every valid output word must match the head of the expected queue.
    always @(negedge clk) begin
        if (chk_en && !rst && dout_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_word: got %0h expected none", dout);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("dout", dout, e.d);
                check("dout_sof", {31'd0, dout_sof}, {31'd0, e.sof});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", dout, 32'd0);
        check("rst_valid", {31'd0, dout_valid}, 32'd0);
        check("rst_sof", {31'd0, dout_sof}, 32'd0);
        check("rst_frame_num", frame_num, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        rst = 1'b0;

        // Pass-through with no marker, two-cycle latency
        push(32'd1, 1'b0);
        push(32'd2, 1'b0);
        push(32'd3, 1'b0);
        drive(1'b0, 1'b1, 32'd1);
        drive(1'b0, 1'b1, 32'd2);
        check("pass_latency_dout", dout, 32'd1);
        check("pass_latency_valid", {31'd0, dout_valid}, 32'd1);
        drive(1'b0, 1'b1, 32'd3);
        drain();

        // First header after 5 samples, marker held 101 cycles
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push(32'd11 + 32'(i), 1'b0);
            drive(1'b0, 1'b1, 32'd11 + 32'(i));
        end
        repeat (3) drive(1'b0, 1'b0, 32'd0);
        push_hdr(32'd0, 32'd5);
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        check("hdr_latency_sync", dout, EXP_SYNC);
        check("hdr_latency_sof", {31'd0, dout_sof}, 32'd1);
        check("frame_num_before", frame_num, 32'd0);
        repeat (99) drive(1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        check("frame_num_after", frame_num, 32'd1);
        drain();

        // Sample on the exact edge cycle counts toward the closing frame
        for (int i = 0; i < 9; i++) begin
            push(32'd21 + 32'(i), 1'b0);
            drive(1'b0, 1'b1, 32'd21 + 32'(i));
        end
        repeat (3) drive(1'b0, 1'b0, 32'd0);
        push_hdr(32'd1, 32'd10);
        push(32'd30, 1'b0);
        drive(1'b1, 1'b1, 32'd30);
        repeat (4) drive(1'b1, 1'b0, 32'd0);
        repeat (2) drive(1'b0, 1'b0, 32'd0);
        drain();

        // Samples spanning the header are buffered; new frame count started at 0
        push_hdr(32'd2, 32'd1);
        for (int i = 0; i < 4; i++) begin
            push(32'd41 + 32'(i), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'd41 + 32'(i));
        end
        drive(1'b0, 1'b0, 32'd0);
        drain();
        check("buffer_no_overflow", {31'd0, overflow}, 32'd0);

        // Reset asserted while HDR1 is the current state
        drive(1'b1, 1'b0, 32'd0);
        drive(1'b1, 1'b0, 32'd0);
        rst   = 1'b1;
        ms_in = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_dout", dout, 32'd0);
        check("midrst_valid", {31'd0, dout_valid}, 32'd0);
        check("midrst_sof", {31'd0, dout_sof}, 32'd0);
        check("midrst_frame_num", frame_num, 32'd0);
        check("midrst_overflow", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        push(32'd61, 1'b0);
        push(32'd62, 1'b0);
        drive(1'b0, 1'b1, 32'd61);
        drive(1'b0, 1'b1, 32'd62);
        repeat (3) drive(1'b0, 1'b0, 32'd0);
        push_hdr(32'd0, 32'd2);
        repeat (3) drive(1'b1, 1'b0, 32'd0);
        drive(1'b0, 1'b0, 32'd0);
        drain();

        // Continuous input with markers every 20 cycles: third header overflows
        do_reset();
        chk_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 45) check("ovf_before_third", {31'd0, overflow}, 32'd0);
            if (i == 47) check("ovf_at_full", {31'd0, overflow}, 32'd0);
            if (i == 48) check("ovf_after_drop", {31'd0, overflow}, 32'd1);
            drive((i % 20) == 5, 1'b1, 32'd100 + 32'(i));
        end
        repeat (20) drive(1'b0, 1'b0, 32'd0);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        do_reset();
        check("ovf_cleared", {31'd0, overflow}, 32'd0);
        chk_en = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
